// File: rtl/nios2_mul_sequencer.sv
// rtl/nios2_mul_sequencer.sv - 32x32 multiply sequencer driving a 32x4 multiplier cell
module nios2_mul_sequencer #(
  parameter int CELL_LATENCY = 1,
  parameter int EARLY_EXIT   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  input  logic [31:0] cell_result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  k_q, k_d;

  // (valid, shift) tracking for products still inside the cell; index
  // CELL_LATENCY-1 lines up with the value currently on cell_result.
  logic [CELL_LATENCY-1:0] vld_q;
  logic [2:0]              sh_q [CELL_LATENCY];

  logic        issue;
  logic        accept;
  logic        older_in_flight;
  logic        last_nibble;
  logic [3:0]  nibble;
  logic [5:0]  rest_sh;
  logic [31:0] b_rest;
  logic [31:0] acc_sum;

  // Nibble selection, early-exit test and the shifted accumulate of the arriving product.
  always_comb begin
    nibble      = b_q[{k_q, 2'b00} +: 4];
    rest_sh     = {1'b0, k_q, 2'b00} + 6'd4;
    b_rest      = b_q >> rest_sh;
    last_nibble = (k_q == 3'd7) || ((EARLY_EXIT != 0) && (b_rest == 32'd0));
    acc_sum     = acc_q + (cell_result << {sh_q[CELL_LATENCY-1], 2'b00});
  end

  // Any product still in flight behind the one now arriving from the cell.
  always_comb begin
    older_in_flight = 1'b0;
    for (int i = 0; i < CELL_LATENCY - 1; i++) begin
      older_in_flight = older_in_flight | vld_q[i];
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    acc_d     = acc_q;
    result_d  = result_q;
    issue     = 1'b0;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cell_src1 = 32'd0;
    cell_src2 = 32'd0;

    if (vld_q[CELL_LATENCY-1]) begin
      acc_d = acc_sum;
    end

    case (state_q)
      S_IDLE: begin
        accept = start;
      end
      S_RUN: begin
        busy      = 1'b1;
        issue     = 1'b1;
        cell_src1 = a_q;
        cell_src2 = {28'd0, nibble};
        k_d       = k_q + 3'd1;
        if (last_nibble) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (vld_q[CELL_LATENCY-1] && !older_in_flight) begin
          state_d  = S_DONE;
          result_d = acc_sum;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      a_d     = src1;
      b_d     = src2;
      acc_d   = 32'd0;
      k_d     = 3'd0;
      state_d = S_RUN;
    end
  end

  assign result = result_q;

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 32'd0;
      result_q <= 32'd0;
      k_q      <= 3'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      k_q      <= k_d;
    end
  end

  // Shift pipeline mirroring the cell latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < CELL_LATENCY; i++) begin
        sh_q[i] <= 3'd0;
      end
    end else begin
      vld_q[0] <= issue;
      sh_q[0]  <= k_q;
      for (int i = 1; i < CELL_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        sh_q[i]  <= sh_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_nios2_mul_sequencer.sv
// tb/tb_nios2_mul_sequencer.sv - directed checks for nios2_mul_sequencer
module tb_nios2_mul_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Instance a: default parameters
  logic        a_start = 1'b0;
  logic [31:0] a_src1 = '0, a_src2 = '0;
  logic        a_busy, a_done;
  logic [31:0] a_result, a_cs1, a_cs2;
  logic [31:0] a_cr = '0;
  always @(posedge clk) a_cr <= a_cs1 * a_cs2;

  // Instance e: EARLY_EXIT=1
  logic        e_start = 1'b0;
  logic [31:0] e_src1 = '0, e_src2 = '0;
  logic        e_busy, e_done;
  logic [31:0] e_result, e_cs1, e_cs2;
  logic [31:0] e_cr = '0;
  always @(posedge clk) e_cr <= e_cs1 * e_cs2;

  // Instance l: CELL_LATENCY=2
  logic        l_start = 1'b0;
  logic [31:0] l_src1 = '0, l_src2 = '0;
  logic        l_busy, l_done;
  logic [31:0] l_result, l_cs1, l_cs2;
  logic [31:0] l_p1 = '0, l_cr = '0;
  always @(posedge clk) begin
    l_p1 <= l_cs1 * l_cs2;
    l_cr <= l_p1;
  end

  nios2_mul_sequencer #(.CELL_LATENCY(1), .EARLY_EXIT(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .src1(a_src1), .src2(a_src2),
    .busy(a_busy), .done(a_done), .result(a_result),
    .cell_src1(a_cs1), .cell_src2(a_cs2), .cell_result(a_cr)
  );

  nios2_mul_sequencer #(.CELL_LATENCY(1), .EARLY_EXIT(1)) u_dut_e (
    .clk(clk), .reset_n(reset_n), .start(e_start), .src1(e_src1), .src2(e_src2),
    .busy(e_busy), .done(e_done), .result(e_result),
    .cell_src1(e_cs1), .cell_src2(e_cs2), .cell_result(e_cr)
  );

  nios2_mul_sequencer #(.CELL_LATENCY(2), .EARLY_EXIT(0)) u_dut_l (
    .clk(clk), .reset_n(reset_n), .start(l_start), .src1(l_src1), .src2(l_src2),
    .busy(l_busy), .done(l_done), .result(l_result),
    .cell_src1(l_cs1), .cell_src2(l_cs2), .cell_result(l_cr)
  );

  // Present a start to one instance for exactly one rising edge (E0).
  task automatic issue(input int which, input logic [31:0] s1, input logic [31:0] s2);
    case (which)
      0: begin a_start = 1'b1; a_src1 = s1; a_src2 = s2; end
      1: begin e_start = 1'b1; e_src1 = s1; e_src2 = s2; end
      default: begin l_start = 1'b1; l_src1 = s1; l_src2 = s2; end
    endcase
    @(posedge clk);
    #1;
    a_start = 1'b0;
    e_start = 1'b0;
    l_start = 1'b0;
  endtask

  // Count rising edges until done is seen; -1 when the bound expires.
  task automatic wait_done(input int which, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ((which == 0 && a_done) || (which == 1 && e_done) || (which == 2 && l_done)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({a_busy, a_done, a_result, a_cs1, a_cs2} !== 98'd0)
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b result=%h cs1=%h cs2=%h expected all 0",
                 i, a_busy, a_done, a_result, a_cs1, a_cs2);
      else passed++;
    end
  endtask

  task automatic test_basic;
    int n;
    issue(0, 32'h0000FFFF, 32'h00010001);
    wait_done(0, n);
    checks++;
    if (n !== 9) $display("FAIL basic_latency: got %0d expected 9", n); else passed++;
    checks++;
    if (a_result !== 32'hFFFFFFFF) $display("FAIL basic_result: got %h expected ffffffff", a_result); else passed++;
    checks++;
    if (a_busy !== 1'b0) $display("FAIL basic_busy_in_done: got %b expected 0", a_busy); else passed++;
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0) $display("FAIL basic_done_pulse_width: got %b expected 0", a_done); else passed++;
    issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, n);
    checks++;
    if (n !== 9) $display("FAIL wrap_latency: got %0d expected 9", n); else passed++;
    checks++;
    if (a_result !== 32'h00000001) $display("FAIL wrap_result: got %h expected 00000001", a_result); else passed++;
  endtask

  task automatic test_cell_drive;
    logic [31:0] exp_cs1, exp_cs2;
    @(negedge clk);
    issue(0, 32'h00000003, 32'h87654321);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_cs1 = (i < 8) ? 32'h00000003 : 32'd0;
      exp_cs2 = (i < 8) ? i + 1 : 32'd0;
      checks++;
      if (a_cs1 !== exp_cs1 || a_cs2 !== exp_cs2)
        $display("FAIL cell_drive cycle %0d: cs1=%h cs2=%h expected cs1=%h cs2=%h",
                 i, a_cs1, a_cs2, exp_cs1, exp_cs2);
      else passed++;
    end
    checks++;
    if (a_done !== 1'b1) $display("FAIL cell_drive_done: got %b expected 1", a_done); else passed++;
    checks++;
    if (a_result !== 32'h962FC963) $display("FAIL cell_drive_result: got %h expected 962fc963", a_result); else passed++;
  endtask

  task automatic test_ignore_start;
    int n;
    @(negedge clk);
    issue(0, 32'd5, 32'd6);
    @(negedge clk);
    @(negedge clk);
    a_start = 1'b1;
    a_src1 = 32'h00000100;
    a_src2 = 32'h00000100;
    @(negedge clk);
    a_start = 1'b0;
    wait_done(0, n);
    checks++;
    if (n !== 7) $display("FAIL ignore_latency: got %0d expected 7", n); else passed++;
    checks++;
    if (a_result !== 32'h0000001E) $display("FAIL ignore_result: got %h expected 0000001e", a_result); else passed++;
  endtask

  task automatic test_back_to_back;
    int n;
    // Currently in the done cycle of the previous request.
    issue(0, 32'h00000010, 32'h00000010);
    checks++;
    if (a_busy !== 1'b1) $display("FAIL b2b_busy: got %b expected 1", a_busy); else passed++;
    wait_done(0, n);
    checks++;
    if (n !== 9) $display("FAIL b2b_latency: got %0d expected 9", n); else passed++;
    checks++;
    if (a_result !== 32'h00000100) $display("FAIL b2b_result: got %h expected 00000100", a_result); else passed++;
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    issue(0, 32'h0000FFFF, 32'h0000FFFF);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_done, a_result, a_cs1, a_cs2} !== 98'd0)
      $display("FAIL reset_mid_outputs: busy=%b done=%b result=%h cs1=%h cs2=%h expected all 0",
               a_busy, a_done, a_result, a_cs1, a_cs2);
    else passed++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_done || a_busy) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", seen); else passed++;
  endtask

  task automatic test_early_exit;
    int n;
    issue(1, 32'd7, 32'h00000003);
    wait_done(1, n);
    checks++;
    if (n !== 2) $display("FAIL ee_latency: got %0d expected 2", n); else passed++;
    checks++;
    if (e_result !== 32'h00000015) $display("FAIL ee_result: got %h expected 00000015", e_result); else passed++;
    @(negedge clk);
    issue(1, 32'h12345678, 32'h00000000);
    wait_done(1, n);
    checks++;
    if (n !== 2) $display("FAIL ee_zero_latency: got %0d expected 2", n); else passed++;
    checks++;
    if (e_result !== 32'h00000000) $display("FAIL ee_zero_result: got %h expected 00000000", e_result); else passed++;
    @(negedge clk);
    issue(1, 32'd2, 32'h00100000);
    wait_done(1, n);
    checks++;
    if (n !== 7) $display("FAIL ee_nib5_latency: got %0d expected 7", n); else passed++;
    checks++;
    if (e_result !== 32'h00200000) $display("FAIL ee_nib5_result: got %h expected 00200000", e_result); else passed++;
  endtask

  task automatic test_latency2;
    int n;
    issue(2, 32'h0000FFFF, 32'h00010001);
    wait_done(2, n);
    checks++;
    if (n !== 10) $display("FAIL lat2_latency: got %0d expected 10", n); else passed++;
    checks++;
    if (l_result !== 32'hFFFFFFFF) $display("FAIL lat2_result: got %h expected ffffffff", l_result); else passed++;
    @(negedge clk);
    issue(2, 32'h00000003, 32'h87654321);
    wait_done(2, n);
    checks++;
    if (n !== 10) $display("FAIL lat2_b_latency: got %0d expected 10", n); else passed++;
    checks++;
    if (l_result !== 32'h962FC963) $display("FAIL lat2_b_result: got %h expected 962fc963", l_result); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cell_drive();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_early_exit();
    test_latency2();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
